// File: rtl/pmcc_code_mem_if.sv
// Ibex-style data bus between a core LSU (master) and a memory slave.
interface ibex_data_bus;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [6:0]  rdata_intg;
  logic        err;

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, rdata_intg, err
  );

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, rdata_intg, err
  );
endinterface

// File: rtl/pmcc_code_mem.sv
// PMCC code memory: bus slave for code load/readback plus a never-stalling
// instruction fetch port with write-first forwarding on same-word collisions.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access outstanding; gnt follows req
// WAIT    | access performed, counting down WAIT_STATES before response
// RESP    | rvalid cycle; with zero wait states a new access may be granted
module pmcc_code_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  ibex_data_bus.slave   data_bus,
  input  logic          write_lock,
  input  logic          fetch_en,
  input  logic [AW-1:0] pc_if,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          instr_err
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd1;
  localparam logic [1:0]  ST_RESP   = 2'd2;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [1:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
  localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [1:0]    state;
  logic [1:0]    wait_cnt;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [AW-1:0] bus_idx;
  logic          bus_oor;
  logic          fetch_oor;
  logic          gnt_int;
  logic          wr_commit;
  logic [31:0]   bus_word;
  logic [31:0]   merged;
  logic [31:0]   fetch_word;
  logic          unused_addr;

  // Block select is done upstream, so only the word-index bits matter here.
  assign bus_idx     = data_bus.addr[AW+1:2];
  assign unused_addr = ^{data_bus.addr[31:AW+2], data_bus.addr[1:0]};
  assign bus_oor     = {1'b0, bus_idx} >= DEPTH_W;
  assign fetch_oor   = {1'b0, pc_if} >= DEPTH_W;

  always_comb begin
    gnt_int = 1'b0;
    if (rst_n && data_bus.req) begin
      case (state)
        ST_IDLE: gnt_int = 1'b1;
        ST_RESP: gnt_int = (WAIT_STATES == 0);
        default: gnt_int = 1'b0;
      endcase
    end
  end

  assign wr_commit = gnt_int & data_bus.we & ~bus_oor & ~write_lock;
  assign bus_word  = bus_oor ? 32'h0 : mem[bus_idx];

  always_comb begin
    merged = bus_word;
    for (int i = 0; i < 4; i++) begin
      if (data_bus.be[i]) merged[8*i +: 8] = data_bus.wdata[8*i +: 8];
    end
  end

  // Write-first: a fetch of the word being written sees the merged value.
  always_comb begin
    fetch_word = 32'h0;
    if (fetch_oor)
      fetch_word = NOP;
    else if (wr_commit && (bus_idx == pc_if))
      fetch_word = merged;
    else
      fetch_word = mem[pc_if];
  end

  // Array is deliberately not reset so code survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[bus_idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (gnt_int) begin
            state    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            wait_cnt <= WAIT_LOAD;
            err_q    <= bus_oor | (data_bus.we & write_lock);
            rdata_q  <= (data_bus.we | bus_oor) ? 32'h0 : bus_word;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      instr_err   <= 1'b0;
    end else begin
      if (fetch_en) instr <= fetch_word;
      instr_valid <= fetch_en;
      instr_err   <= fetch_en & fetch_oor;
    end
  end

  assign data_bus.gnt        = gnt_int;
  assign data_bus.rvalid     = (state == ST_RESP);
  assign data_bus.rdata      = rdata_q;
  assign data_bus.err        = err_q;
  assign data_bus.rdata_intg = 7'h0;

endmodule

// File: tb/tb_pmcc_code_mem.sv
// Bench for pmcc_code_mem: three configurations (256/0, 200/2, 256/3 wait states)
// driven from one vector table plus directed multi-cycle sequences.
module tb_pmcc_code_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       fetch_en;
  logic       write_lock;
  logic [7:0] pc_if;

  logic        req_v   [3];
  logic        we_v    [3];
  logic [31:0] addr_v  [3];
  logic [3:0]  be_v    [3];
  logic [31:0] wdata_v [3];
  logic        gnt_v   [3];
  logic        rvalid_v[3];
  logic        err_v   [3];
  logic [31:0] rdata_v [3];
  logic [6:0]  intg_v  [3];
  logic [31:0] instr_v [3];
  logic        iv_v    [3];
  logic        ie_v    [3];

  int n_chk  = 0;
  int n_fail = 0;
  int ws_of [3] = '{0, 2, 3};

  ibex_data_bus bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].req   = req_v[g];
    assign bus[g].we    = we_v[g];
    assign bus[g].addr  = addr_v[g];
    assign bus[g].be    = be_v[g];
    assign bus[g].wdata = wdata_v[g];
    assign gnt_v[g]     = bus[g].gnt;
    assign rvalid_v[g]  = bus[g].rvalid;
    assign err_v[g]     = bus[g].err;
    assign rdata_v[g]   = bus[g].rdata;
    assign intg_v[g]    = bus[g].rdata_intg;
  end

  pmcc_code_mem #(.DEPTH(256), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .data_bus(bus[0]), .write_lock(write_lock),
    .fetch_en(fetch_en), .pc_if(pc_if),
    .instr(instr_v[0]), .instr_valid(iv_v[0]), .instr_err(ie_v[0]));

  pmcc_code_mem #(.DEPTH(200), .WAIT_STATES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .data_bus(bus[1]), .write_lock(write_lock),
    .fetch_en(fetch_en), .pc_if(pc_if),
    .instr(instr_v[1]), .instr_valid(iv_v[1]), .instr_err(ie_v[1]));

  pmcc_code_mem #(.DEPTH(256), .WAIT_STATES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .data_bus(bus[2]), .write_lock(write_lock),
    .fetch_en(fetch_en), .pc_if(pc_if),
    .instr(instr_v[2]), .instr_valid(iv_v[2]), .instr_err(ie_v[2]));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        lock;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout, expected event never seen", name);
  endtask

  // Returns at posedge+1 so the next access starts from a clean cycle.
  task automatic bus_xfer(input int s, input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int gwait, output int lat);
    logic granted;
    granted = 1'b0;
    gwait = 0;
    lat = -1;
    rd = 32'h0;
    er = 1'b0;
    req_v[s] = 1'b1; we_v[s] = we; addr_v[s] = a; be_v[s] = be; wdata_v[s] = wd;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (gnt_v[s]) granted = 1'b1;
      else begin
        gwait++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    req_v[s] = 1'b0; we_v[s] = 1'b0;
    if (!granted) begin
      timeout($sformatf("gnt_s%0d", s));
      return;
    end
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(negedge clk);
      if (rvalid_v[s]) begin
        lat = n;
        rd = rdata_v[s];
        er = err_v[s];
      end
      @(posedge clk); #1;
    end
    if (lat < 0) timeout($sformatf("rvalid_s%0d", s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          gw, lat, rv_cnt, phase, nrv;
    logic [8:0]  gp, rp;
    logic [31:0] rd_a, rd_b;

    vt[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0,         1'b0};
    vt[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_0008, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
    vt[6]  = '{1'b1, 32'h0000_0008, 4'hF, 32'h1234_5678, 1'b1, 32'h0,         1'b1};
    vt[7]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
    vt[8]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0};
    vt[9]  = '{1'b1, 32'h0000_0014, 4'hF, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
    vt[10] = '{1'b0, 32'hFFFF_F010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
    vt[11] = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};

    for (int s = 0; s < 3; s++) begin
      req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = 32'h0; be_v[s] = 4'h0; wdata_v[s] = 32'h0;
    end
    fetch_en = 1'b0; write_lock = 1'b0; pc_if = 8'h0;

    // reset state, with a request pending to show gnt is held off
    req_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt_forced", 32'(gnt_v[0]), 32'h0);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_rvalid_s%0d", s), 32'(rvalid_v[s]), 32'h0);
      chk($sformatf("rst_err_s%0d", s), 32'(err_v[s]), 32'h0);
      chk($sformatf("rst_rdata_s%0d", s), rdata_v[s], 32'h0);
      chk($sformatf("rst_intg_s%0d", s), 32'(intg_v[s]), 32'h0);
      chk($sformatf("rst_instr_s%0d", s), instr_v[s], 32'h0);
      chk($sformatf("rst_ivalid_s%0d", s), 32'(iv_v[s]), 32'h0);
      chk($sformatf("rst_ierr_s%0d", s), 32'(ie_v[s]), 32'h0);
    end
    req_v[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // vector table on every configuration
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 12; i++) begin
        write_lock = vt[i].lock;
        bus_xfer(s, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, rd, er, gw, lat);
        chk($sformatf("vec%0d_s%0d_rdata", i, s), rd, vt[i].exp_rdata);
        chk($sformatf("vec%0d_s%0d_err", i, s), 32'(er), 32'(vt[i].exp_err));
        chk($sformatf("vec%0d_s%0d_lat", i, s), 32'(lat), 32'(ws_of[s] + 1));
      end
    end
    write_lock = 1'b0;

    // plain fetch, then hold without fetch_en
    pc_if = 8'd8; fetch_en = 1'b1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("fetch8_instr_s%0d", s), instr_v[s], 32'h11BB_33DD);
      chk($sformatf("fetch8_valid_s%0d", s), 32'(iv_v[s]), 32'h1);
      chk($sformatf("fetch8_err_s%0d", s), 32'(ie_v[s]), 32'h0);
    end
    @(negedge clk);
    chk("fetch_hold_valid", 32'(iv_v[0]), 32'h0);
    chk("fetch_hold_instr", instr_v[0], 32'h11BB_33DD);
    @(posedge clk); #1;

    // DEPTH=200 boundaries
    bus_xfer(1, 1'b1, 32'h0000_031C, 4'hF, 32'h5A5A_A5A5, rd, er, gw, lat);
    chk("d200_wr199_err", 32'(er), 32'h0);
    bus_xfer(1, 1'b0, 32'h0000_0320, 4'hF, 32'h0, rd, er, gw, lat);
    chk("d200_rd200_err", 32'(er), 32'h1);
    chk("d200_rd200_rdata", rd, 32'h0);
    bus_xfer(1, 1'b1, 32'h0000_0320, 4'hF, 32'h1111_1111, rd, er, gw, lat);
    chk("d200_wr200_err", 32'(er), 32'h1);
    pc_if = 8'd199; fetch_en = 1'b1;
    @(posedge clk); #1;
    pc_if = 8'd201;
    @(negedge clk);
    chk("d200_f199_instr", instr_v[1], 32'h5A5A_A5A5);
    chk("d200_f199_err", 32'(ie_v[1]), 32'h0);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    @(negedge clk);
    chk("d200_f201_instr", instr_v[1], 32'h0000_0013);
    chk("d200_f201_err", 32'(ie_v[1]), 32'h1);
    chk("d200_f201_valid", 32'(iv_v[1]), 32'h1);
    chk("d256_f201_err", 32'(ie_v[0]), 32'h0);
    @(posedge clk); #1;

    // write/fetch collision on u0: write-first with byte merge
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h14; be_v[0] = 4'h1; wdata_v[0] = 32'h0000_00FF;
    fetch_en = 1'b1; pc_if = 8'd5;
    @(negedge clk);
    chk("coll_gnt", 32'(gnt_v[0]), 32'h1);
    @(posedge clk); #1;
    req_v[0] = 1'b0; we_v[0] = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    chk("coll_instr", instr_v[0], 32'h1234_56FF);
    chk("coll_rvalid", 32'(rvalid_v[0]), 32'h1);
    chk("coll_err", 32'(err_v[0]), 32'h0);
    @(posedge clk); #1;
    bus_xfer(0, 1'b0, 32'h14, 4'hF, 32'h0, rd, er, gw, lat);
    chk("coll_readback", rd, 32'h1234_56FF);

    // read/fetch collision: both see the stored word
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10;
    fetch_en = 1'b1; pc_if = 8'd4;
    @(negedge clk);
    @(posedge clk); #1;
    req_v[0] = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    chk("rdcoll_instr", instr_v[0], 32'hDEAD_BEEF);
    chk("rdcoll_rdata", rdata_v[0], 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // back-to-back reads with two wait states on u1
    bus_xfer(1, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, rd, er, gw, lat);
    bus_xfer(1, 1'b1, 32'h4, 4'hF, 32'h600D_CAFE, rd, er, gw, lat);
    gp = '0; rp = '0; phase = 0; nrv = 0; rd_a = 32'h0; rd_b = 32'h0;
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      gp[c] = gnt_v[1];
      rp[c] = rvalid_v[1];
      if (rvalid_v[1]) begin
        if (nrv == 0) rd_a = rdata_v[1];
        else          rd_b = rdata_v[1];
        nrv++;
      end
      @(posedge clk); #1;
      if (gp[c]) begin
        phase++;
        if (phase == 1) addr_v[1] = 32'h4;
        else            req_v[1] = 1'b0;
      end
    end
    req_v[1] = 1'b0;
    chk("b2b_gnt_pattern", 32'(gp), 32'h011);
    chk("b2b_rvalid_pattern", 32'(rp), 32'h088);
    chk("b2b_rdata0", rd_a, 32'h0BAD_F00D);
    chk("b2b_rdata1", rd_b, 32'h600D_CAFE);

    // reset during a three-wait-state read on u2
    fetch_en = 1'b1; pc_if = 8'd4;
    req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 32'h10;
    @(negedge clk);
    chk("rstmid_gnt", 32'(gnt_v[2]), 32'h1);
    @(posedge clk); #1;
    req_v[2] = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_rvalid", 32'(rvalid_v[2]), 32'h0);
    chk("rstmid_instr", instr_v[0], 32'h0);
    chk("rstmid_ivalid", 32'(iv_v[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid_v[2]) rv_cnt++;
    end
    chk("rstmid_no_rvalid", 32'(rv_cnt), 32'h0);
    @(posedge clk); #1;
    bus_xfer(2, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, gw, lat);
    chk("rstmid_idle_gnt", 32'(gw), 32'h0);
    chk("rstmid_rdata", rd, 32'hDEAD_BEEF);
    chk("rstmid_lat", 32'(lat), 32'h4);
    bus_xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, gw, lat);
    chk("array_survives_rst", rd, 32'h11BB_33DD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
